// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store unit: decodes RV32I access size, runs a req/ack bus
// handshake with timeout, and returns lane-selected, extended load data.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_wen,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        lane_q, lane_d;
  logic [2:0]        f3_q, f3_d;
  logic              is_load_q, is_load_d;

  logic [31:0]       load_data_d;
  logic              load_valid_d, misalign_d, bus_err_d;
  logic              bus_req_d, bus_we_d;
  logic [31:0]       bus_addr_d, bus_wdata_d;
  logic [3:0]        bus_be_d;

  logic              acc, legal, f3_ok, align_ok;
  logic [3:0]        be_c;
  logic [31:0]       wdata_c, lane_word, ext_c;

  assign acc = mem_read | mem_wen;

  // Legality: funct3 set depends on load vs store, plus natural alignment
  always_comb begin
    f3_ok = 1'b0;
    if (mem_read) begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
        default:                                f3_ok = 1'b0;
      endcase
    end else begin
      case (funct3)
        3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
        default:                f3_ok = 1'b0;
      endcase
    end
    case (funct3[1:0])
      2'b01:   align_ok = ~addr[0];
      2'b10:   align_ok = (addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    legal = acc & ~(mem_read & mem_wen) & f3_ok & align_ok;
  end

  // Byte enables and lane-replicated store data
  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        be_c    = 4'(4'b0001 << addr[1:0]);
        wdata_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_c    = 4'(4'b0011 << {addr[1], 1'b0});
        wdata_c = {2{wdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = wdata;
      end
    endcase
  end

  // Load lane select and sign/zero extension; funct3[2] marks unsigned
  always_comb begin
    lane_word = bus_rdata >> {lane_q, 3'b000};
    case (f3_q[1:0])
      2'b00:   ext_c = {{24{~f3_q[2] & lane_word[7]}}, lane_word[7:0]};
      2'b01:   ext_c = {{16{~f3_q[2] & lane_word[15]}}, lane_word[15:0]};
      default: ext_c = lane_word;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lane_d       = lane_q;
    f3_d         = f3_q;
    is_load_d    = is_load_q;
    load_data_d  = load_data;
    load_valid_d = 1'b0;
    misalign_d   = 1'b0;
    bus_err_d    = 1'b0;
    bus_req_d    = bus_req;
    bus_we_d     = bus_we;
    bus_addr_d   = bus_addr;
    bus_be_d     = bus_be;
    bus_wdata_d  = bus_wdata;
    stall        = 1'b0;

    case (state_q)
      IDLE: begin
        if (acc) begin
          if (legal) begin
            stall       = rst_n;
            state_d     = REQ;
            cnt_d       = '0;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_wen;
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_be_d    = be_c;
            bus_wdata_d = wdata_c;
            lane_d      = addr[1:0];
            f3_d        = funct3;
            is_load_d   = mem_read;
          end else begin
            misalign_d = 1'b1;
          end
        end
      end
      REQ: begin
        stall = rst_n;
        if (bus_ack) begin
          bus_req_d    = 1'b0;
          state_d      = DONE;
          load_valid_d = is_load_q;
          if (is_load_q) load_data_d = ext_c;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          bus_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lane_q       <= '0;
      f3_q         <= '0;
      is_load_q    <= 1'b0;
      load_data    <= '0;
      load_valid   <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_be       <= '0;
      bus_wdata    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lane_q       <= lane_d;
      f3_q         <= f3_d;
      is_load_q    <= is_load_d;
      load_data    <= load_data_d;
      load_valid   <= load_valid_d;
      misalign_err <= misalign_d;
      bus_err      <= bus_err_d;
      bus_req      <= bus_req_d;
      bus_we       <= bus_we_d;
      bus_addr     <= bus_addr_d;
      bus_be       <= bus_be_d;
      bus_wdata    <= bus_wdata_d;
    end
  end

endmodule
